// File: rtl/retospect_bs_loader.sv
// retospect_bs_loader
//   Feeds the neurochip configuration shift chain. Config bytes arrive on a
//   valid/ready stream and are shifted out LSB-first on cfg_bs_o while
//   cfg_en_o is held high for exactly CHAIN_LEN contiguous cycles. The bits
//   returning from the chain end (cfg_ret_i) are folded into a CRC-16-CCITT
//   and compared against the transmit CRC of the previous load. A completed
//   load is followed by a one-cycle neuron init pulse and a one-cycle done.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start_i           begin a load (honoured in IDLE or ERR)
//   in_data_i/in_valid_i/in_ready_o   config byte stream, bit0 first
//   cfg_en_o/cfg_bs_o chain shift enable / serial data
//   cfg_ret_i         chain serial return (combinational from last chain bit)
//   nn_pulse_o        neuron init pulse, 1 cycle after the last bit
//   busy_o            high outside IDLE/ERR
//   done_o            1-cycle pulse, load completed
//   err_underrun_o    a byte was not available when the shifter needed it
//   crc_rx_o          CRC of the bits returned during the last completed load
//   crc_valid_o       a previous completed load exists
//   crc_match_o       crc_rx_o equals the transmit CRC of the load before it
//
// States
//   S_IDLE  | waiting for start
//   S_FILL  | waiting for the first byte of the load
//   S_SHIFT | shifting one chain bit per cycle
//   S_NNP   | neuron init pulse, CRC results latched
//   S_DONE  | done pulse, crc_valid set
//   S_ERR   | byte underrun; waits for start

module retospect_bs_loader #(
  parameter int          CHAIN_LEN = 998,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic        cfg_en_o,
  output logic        cfg_bs_o,
  input  logic        cfg_ret_i,
  output logic        nn_pulse_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_underrun_o,
  output logic [15:0] crc_rx_o,
  output logic        crc_valid_o,
  output logic        crc_match_o
);

  localparam int NBYTES = (CHAIN_LEN + 7) / 8;
  localparam int BW     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int CW     = $clog2(NBYTES + 1);

  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] NBYTES_C = CW'(NBYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SHIFT,
    S_NNP,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    sh_cnt_q, sh_cnt_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_vld_q, hold_vld_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [15:0]   crc_tx_q, crc_tx_d;
  logic [15:0]   crc_acc_q, crc_acc_d;
  logic [15:0]   crc_prev_q, crc_prev_d;
  logic [15:0]   crc_rx_q, crc_rx_d;
  logic          crc_valid_q, crc_valid_d;
  logic          crc_match_q, crc_match_d;
  logic          accept;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      sh_cnt_q    <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      crc_tx_q    <= CRC_INIT;
      crc_acc_q   <= CRC_INIT;
      crc_prev_q  <= CRC_INIT;
      crc_rx_q    <= CRC_INIT;
      crc_valid_q <= 1'b0;
      crc_match_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      sh_cnt_q    <= sh_cnt_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_tx_q    <= crc_tx_d;
      crc_acc_q   <= crc_acc_d;
      crc_prev_q  <= crc_prev_d;
      crc_rx_q    <= crc_rx_d;
      crc_valid_q <= crc_valid_d;
      crc_match_q <= crc_match_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    sh_cnt_d    = sh_cnt_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    crc_tx_d    = crc_tx_q;
    crc_acc_d   = crc_acc_q;
    crc_prev_d  = crc_prev_q;
    crc_rx_d    = crc_rx_q;
    crc_valid_d = crc_valid_q;
    crc_match_d = crc_match_q;
    cfg_en_o    = 1'b0;
    cfg_bs_o    = 1'b0;
    nn_pulse_o  = 1'b0;
    done_o      = 1'b0;

    // Stop requesting once every byte the chain needs has been taken.
    in_ready_o = ((state_q == S_FILL) || (state_q == S_SHIFT)) &&
                 !hold_vld_q && (byte_cnt_q != NBYTES_C);
    accept     = in_valid_i && in_ready_o;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start_i) begin
          state_d    = S_FILL;
          crc_tx_d   = CRC_INIT;
          crc_acc_d  = CRC_INIT;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          sh_cnt_d   = '0;
          hold_vld_d = 1'b0;
        end
      end
      S_FILL: begin
        if (accept) begin
          sh_d       = in_data_i;
          sh_cnt_d   = '0;
          byte_cnt_d = CW'(1);
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cfg_en_o  = 1'b1;
        cfg_bs_o  = sh_q[0];
        crc_tx_d  = crc_step(crc_tx_q, sh_q[0]);
        crc_acc_d = crc_step(crc_acc_q, cfg_ret_i);
        if (accept) begin
          hold_d     = in_data_i;
          hold_vld_d = 1'b1;
          byte_cnt_d = byte_cnt_q + CW'(1);
        end
        if (bit_cnt_q == LAST_BIT) begin
          // Unused high bits of the final byte are simply never shifted.
          state_d    = S_NNP;
          hold_vld_d = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (sh_cnt_q == 3'd7) begin
            // accept can only coincide with an empty hold, so the reload
            // below never races a fresh write into hold.
            if (hold_vld_q) begin
              sh_d       = hold_q;
              sh_cnt_d   = '0;
              hold_vld_d = 1'b0;
            end else begin
              state_d    = S_ERR;
              hold_vld_d = 1'b0;
            end
          end else begin
            sh_d     = {1'b0, sh_q[7:1]};
            sh_cnt_d = sh_cnt_q + 3'd1;
          end
        end
      end
      S_NNP: begin
        nn_pulse_o  = 1'b1;
        crc_rx_d    = crc_acc_q;
        crc_match_d = crc_valid_q && (crc_acc_q == crc_prev_q);
        crc_prev_d  = crc_tx_q;
        state_d     = S_DONE;
      end
      S_DONE: begin
        done_o      = 1'b1;
        crc_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o         = (state_q != S_IDLE) && (state_q != S_ERR);
  assign err_underrun_o = (state_q == S_ERR);
  assign crc_rx_o       = crc_rx_q;
  assign crc_valid_o    = crc_valid_q;
  assign crc_match_o    = crc_match_q;

endmodule

// File: tb/tb_retospect_bs_loader.sv
// Directed bench for retospect_bs_loader: a full-size instance driving a
// 998-bit behavioural chain, and a 5-bit instance for the short-chain case.

module tb_retospect_bs_loader;

  localparam int CL = 998;
  localparam int NB = (CL + 7) / 8;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready;
  logic [7:0]  in_data;
  logic        cfg_en, cfg_bs, cfg_ret, nn_pulse, busy, done, err_underrun;
  logic [15:0] crc_rx;
  logic        crc_valid, crc_match;

  logic        s_reset, s_start, s_in_valid, s_in_ready;
  logic [7:0]  s_in_data;
  logic        s_cfg_en, s_cfg_bs, s_cfg_ret, s_nn, s_busy, s_done, s_err;
  logic [15:0] s_crc_rx;
  logic        s_crc_valid, s_crc_match;

  logic [CL-1:0] chain = '0;
  logic          corrupt = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign cfg_ret   = chain[0] ^ corrupt;
  assign s_cfg_ret = 1'b0;

  always @(posedge clk) begin
    if (cfg_en) chain <= {cfg_bs, chain[CL-1:1]};
  end

  retospect_bs_loader #(.CHAIN_LEN(CL), .CRC_INIT(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .start_i(start),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .cfg_en_o(cfg_en), .cfg_bs_o(cfg_bs), .cfg_ret_i(cfg_ret),
    .nn_pulse_o(nn_pulse), .busy_o(busy), .done_o(done),
    .err_underrun_o(err_underrun), .crc_rx_o(crc_rx),
    .crc_valid_o(crc_valid), .crc_match_o(crc_match)
  );

  retospect_bs_loader #(.CHAIN_LEN(5), .CRC_INIT(16'hFFFF)) dut_s (
    .clk(clk), .reset(s_reset), .start_i(s_start),
    .in_data_i(s_in_data), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .cfg_en_o(s_cfg_en), .cfg_bs_o(s_cfg_bs), .cfg_ret_i(s_cfg_ret),
    .nn_pulse_o(s_nn), .busy_o(s_busy), .done_o(s_done),
    .err_underrun_o(s_err), .crc_rx_o(s_crc_rx),
    .crc_valid_o(s_crc_valid), .crc_match_o(s_crc_match)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_val(input bit incr, input logic [7:0] fill, input int i);
    return incr ? 8'(i) : fill;
  endfunction

  function automatic logic exp_bit(input bit incr, input logic [7:0] fill, input int n);
    logic [7:0] b;
    b = byte_val(incr, fill, n / 8);
    return b[n % 8];
  endfunction

  // CRC-16-CCITT over the 998 bits a load of this pattern puts in the chain.
  function automatic logic [15:0] pat_crc(input bit incr, input logic [7:0] fill, input bit inv);
    logic [15:0] c;
    logic        x;
    c = 16'hFFFF;
    for (int i = 0; i < CL; i++) begin
      x = exp_bit(incr, fill, i) ^ inv;
      c = {c[14:0], 1'b0} ^ ((c[15] ^ x) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // One load on the full-size DUT. Bytes are offered as soon as possible
  // except index `withhold`; with rst_bit >= 0 the task raises reset on the
  // cycle that bit is on the chain and returns.
  task automatic run_load(input bit incr, input logic [7:0] fill,
                          input int withhold, input int rst_bit,
                          output int n_en, output int first_en, output int last_en,
                          output int t_acc, output int t_nn, output int t_done,
                          output int t_err, output int bs_bad, output int n_nn,
                          output int n_done, output int n_acc);
    n_en = 0; first_en = -1; last_en = -1; t_acc = -1; t_nn = -1;
    t_done = -1; t_err = -1; bs_bad = 0; n_nn = 0; n_done = 0; n_acc = 0;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      if (cfg_en) begin
        if (first_en < 0) first_en = c;
        last_en = c;
        if (cfg_bs !== exp_bit(incr, fill, n_en)) bs_bad++;
        n_en++;
      end
      if (nn_pulse) begin n_nn++; t_nn = c; end
      if (done) begin n_done++; t_done = c; end
      if (err_underrun && t_err < 0) t_err = c;
      if (rst_bit >= 0 && cfg_en && n_en == rst_bit + 1) begin
        reset = 1'b1;
        in_valid = 1'b0;
        return;
      end
      if (n_acc < NB && n_acc != withhold) begin
        in_valid = 1'b1;
        in_data  = byte_val(incr, fill, n_acc);
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (n_acc == 0) t_acc = c;
        n_acc++;
      end
      if (t_done >= 0 && c > t_done + 2) break;
      if (t_err >= 0 && c > t_err + 5) break;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  int n_en, first_en, last_en, t_acc, t_nn, t_done, t_err, bs_bad, n_nn, n_done, n_acc;

  task automatic load_ok(input string tag, input bit incr, input logic [7:0] fill);
    run_load(incr, fill, -1, -1, n_en, first_en, last_en, t_acc, t_nn, t_done,
             t_err, bs_bad, n_nn, n_done, n_acc);
    chk({tag, "_done"}, n_done, 1);
    chk({tag, "_bits"}, n_en, CL);
    chk({tag, "_bs"}, bs_bad, 0);
  endtask

  initial begin
    int sen, sbad, sn, sd, sacc, stacc, std;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    s_reset = 1'b1; s_start = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cfg_en", cfg_en, 0);
    chk("rst_cfg_bs", cfg_bs, 0);
    chk("rst_nn", nn_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_underrun, 0);
    chk("rst_crc_rx", crc_rx, 16'hFFFF);
    chk("rst_crc_valid", crc_valid, 0);
    chk("rst_crc_match", crc_match, 0);
    reset = 1'b0;
    s_reset = 1'b0;

    // Incrementing bytes 0x00..0x7C, offered immediately
    load_ok("inc", 1'b1, 8'h00);
    chk("inc_bytes", n_acc, 125);
    chk("inc_contig", last_en - first_en + 1, CL);
    chk("inc_first_en", first_en, t_acc + 1);
    chk("inc_nn_time", t_nn, t_acc + 999);
    chk("inc_done_time", t_done, t_acc + 1000);
    chk("inc_nn_count", n_nn, 1);
    chk("inc_busy_end", busy, 0);

    // CRC readback through the chain model
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    load_ok("a5_1", 1'b0, 8'hA5);
    chk("a5_1_rx", crc_rx, pat_crc(1'b1, 8'h00, 1'b0));
    chk("a5_1_valid", crc_valid, 1);
    chk("a5_1_match", crc_match, 0);
    load_ok("a5_2", 1'b0, 8'hA5);
    chk("a5_2_rx", crc_rx, pat_crc(1'b0, 8'hA5, 1'b0));
    chk("a5_2_match", crc_match, 1);
    load_ok("3c", 1'b0, 8'h3C);
    chk("3c_rx", crc_rx, pat_crc(1'b0, 8'hA5, 1'b0));
    chk("3c_match", crc_match, 1);
    corrupt = 1'b1;
    load_ok("ff", 1'b0, 8'hFF);
    corrupt = 1'b0;
    chk("ff_rx", crc_rx, pat_crc(1'b0, 8'h3C, 1'b1));
    chk("ff_match", crc_match, 0);
    chk("ff_valid", crc_valid, 1);

    // Underrun: byte 3 withheld
    run_load(1'b1, 8'h00, 3, -1, n_en, first_en, last_en, t_acc, t_nn, t_done,
             t_err, bs_bad, n_nn, n_done, n_acc);
    chk("ur_bits", n_en, 24);
    chk("ur_err_time", t_err, last_en + 1);
    chk("ur_bs", bs_bad, 0);
    chk("ur_nn", n_nn, 0);
    chk("ur_done", n_done, 0);
    chk("ur_err_sticky", err_underrun, 1);
    chk("ur_cfg_en", cfg_en, 0);
    chk("ur_busy", busy, 0);
    load_ok("ur_retry", 1'b1, 8'h00);
    chk("ur_retry_err", t_err, -1);

    // Reset in the middle of a load
    run_load(1'b0, 8'h5A, -1, 500, n_en, first_en, last_en, t_acc, t_nn, t_done,
             t_err, bs_bad, n_nn, n_done, n_acc);
    chk("mrst_reached", n_en, 501);
    @(negedge clk);
    chk("mrst_cfg_en", cfg_en, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_crc_valid", crc_valid, 0);
    chk("mrst_crc_match", crc_match, 0);
    reset = 1'b0;
    load_ok("mrst_after", 1'b0, 8'h96);
    chk("mrst_after_valid", crc_valid, 1);

    // Short chain: CHAIN_LEN = 5, one byte 0x1F
    sen = 0; sbad = 0; sn = 0; sd = 0; sacc = 0; stacc = -1; std = -1;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (s_cfg_en) begin
        if (s_cfg_bs !== 1'b1) sbad++;
        sen++;
      end
      if (s_nn) sn++;
      if (s_done) begin sd++; std = c; end
      s_in_valid = 1'b1;
      s_in_data  = (sacc == 0) ? 8'h1F : 8'h00;
      s_start    = (c == 3);
      if (s_in_valid && s_in_ready) begin
        if (sacc == 0) stacc = c;
        sacc++;
      end
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    s_start = 1'b0;
    chk("s5_bits", sen, 5);
    chk("s5_bs", sbad, 0);
    chk("s5_accepted", sacc, 1);
    chk("s5_nn", sn, 1);
    chk("s5_done", sd, 1);
    chk("s5_done_time", std, stacc + 7);
    chk("s5_busy_end", s_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
